// File: rtl/syn_fifo_param_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Status snapshot, also used by the monitor/scoreboard side of the env.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/syn_fifo_param_if.sv
// Producer/consumer handshake bundle for syn_fifo_param.
interface syn_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) ();
    localparam int CNT_W = cnt_width(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // Producer/consumer side
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/syn_fifo_param_mem_dp.sv
// DATA_W x DEPTH storage: synchronous write port, asynchronous read port.
module fifo_mem_dp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    // Contents are deliberately not reset; the control logic never exposes stale words.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/syn_fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, registered status flags,
// error pulses and either a registered read port or first-word-fall-through.
module syn_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_STD
) (
    input logic             clk,
    input logic             rst,
    syn_fifo_param_if.slave bus
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    // Reject illegal configurations at elaboration.
    if (DEPTH < 2) begin : g_bad_depth
        $error("syn_fifo_param: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("syn_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("syn_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    fifo_status_t      r_st;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_wr_accept, w_rd_accept;
    logic [DATA_W-1:0] w_mem_rdata;

    // Pointers wrap at DEPTH-1, so any depth works, not just powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake acceptance and next occupancy. In FWFT mode rd_valid == !empty,
    // so "rd_en while nothing valid" is the same rejection as "rd_en while empty".
    always_comb begin
        w_rd_accept = bus.rd_en & ~r_st.empty;
        w_wr_accept = bus.wr_en & (~r_st.full | w_rd_accept);
        w_cnt_next  = r_count + CNT_W'(w_wr_accept) - CNT_W'(w_rd_accept);
    end

    // Pointers, count and flags; flags come from the next count so they move with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_st     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                          almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
        end else begin
            if (w_wr_accept) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd_accept) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count              <= w_cnt_next;
            r_st.full            <= (w_cnt_next == CNT_W'(DEPTH));
            r_st.empty           <= (w_cnt_next == '0);
            r_st.almost_full     <= (w_cnt_next >= CNT_W'(AF_THRESH));
            r_st.almost_empty    <= (w_cnt_next <= CNT_W'(AE_THRESH));
            r_st.overflow        <= bus.wr_en & ~w_wr_accept;
            r_st.underflow       <= bus.rd_en & r_st.empty;
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    if (FWFT == FIFO_STD) begin : g_std
        logic [DATA_W-1:0] r_rd_data;
        logic              r_rd_valid;

        // Registered read: capture the head on an accepted read, hold otherwise.
        // When full with a simultaneous write, the async read sees the old word.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_accept;
                if (w_rd_accept) r_rd_data <= w_mem_rdata;
            end
        end

        assign bus.rd_data  = r_rd_data;
        assign bus.rd_valid = r_rd_valid;
    end else begin : g_fwft
        // Head is always presented; forced to zero while empty so reset reads 0.
        assign bus.rd_data  = r_st.empty ? '0 : w_mem_rdata;
        assign bus.rd_valid = ~r_st.empty;
    end

    assign bus.count        = r_count;
    assign bus.full         = r_st.full;
    assign bus.empty        = r_st.empty;
    assign bus.almost_full  = r_st.almost_full;
    assign bus.almost_empty = r_st.almost_empty;
    assign bus.overflow     = r_st.overflow;
    assign bus.underflow    = r_st.underflow;
endmodule

// File: tb/tb_syn_fifo_param.sv
// Bench for syn_fifo_param: three configurations share one stimulus stream
// and are each compared against a queue-style occupancy model every cycle.
//   dut 0: DEPTH 16, AF 14, AE 2, standard read
//   dut 1: DEPTH 5,  AF 4,  AE 1, standard read
//   dut 2: DEPTH 4,  AF 3,  AE 1, FWFT
module tb_syn_fifo_param;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    syn_fifo_param_if #(.DATA_W(8), .DEPTH(16)) ia ();
    syn_fifo_param_if #(.DATA_W(8), .DEPTH(5))  ib ();
    syn_fifo_param_if #(.DATA_W(8), .DEPTH(4))  ic ();

    assign ia.wr_en = wr_en;  assign ia.rd_en = rd_en;  assign ia.wr_data = wr_data;
    assign ib.wr_en = wr_en;  assign ib.rd_en = rd_en;  assign ib.wr_data = wr_data;
    assign ic.wr_en = wr_en;  assign ic.rd_en = rd_en;  assign ic.wr_data = wr_data;

    syn_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(FIFO_STD))
        u_a (.clk(clk), .rst(rst), .bus(ia));
    syn_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(FIFO_STD))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    syn_fifo_param #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(FIFO_FWFT))
        u_c (.clk(clk), .rst(rst), .bus(ic));

    // Observed outputs: {rd_valid, rd_data, full, empty, af, ae, ovf, udf, count[4:0]}.
    // FWFT rd_data is only meaningful while rd_valid is high.
    logic [19:0] obs [3];
    assign obs[0] = {ia.rd_valid, ia.rd_data, ia.full, ia.empty, ia.almost_full,
                     ia.almost_empty, ia.overflow, ia.underflow, ia.count};
    assign obs[1] = {ib.rd_valid, ib.rd_data, ib.full, ib.empty, ib.almost_full,
                     ib.almost_empty, ib.overflow, ib.underflow, 2'b00, ib.count};
    assign obs[2] = {ic.rd_valid, (ic.rd_valid ? ic.rd_data : 8'h00), ic.full, ic.empty,
                     ic.almost_full, ic.almost_empty, ic.overflow, ic.underflow, 2'b00, ic.count};

    localparam logic [19:0] RST_VEC = 20'h00280;  // empty=1, almost_empty=1, all else 0

    // ---------------- reference model ----------------
    logic [7:0] mq [3][32];
    int         mhead [3];
    int         msize [3];
    bit         e_rdv [3], e_ovf [3], e_udf [3];
    logic [7:0] e_rdd [3];

    function automatic int m_depth(input int d); return (d == 0) ? 16 : (d == 1) ? 5 : 4; endfunction
    function automatic int m_af(input int d);    return (d == 0) ? 14 : (d == 1) ? 4 : 3; endfunction
    function automatic int m_ae(input int d);    return (d == 0) ? 2 : 1; endfunction
    function automatic bit m_fwft(input int d);  return d == 2; endfunction

    task automatic model_step(input int d, input bit we, input bit re, input logic [7:0] wd, input bit r);
        bit ra, wa;
        if (r) begin
            mhead[d] = 0; msize[d] = 0;
            e_rdv[d] = 0; e_rdd[d] = 8'h00; e_ovf[d] = 0; e_udf[d] = 0;
        end else begin
            ra = re && (msize[d] > 0);
            wa = we && ((msize[d] < m_depth(d)) || ra);
            e_ovf[d] = we && !wa;
            e_udf[d] = re && (msize[d] == 0);
            e_rdv[d] = ra;
            if (ra) begin
                e_rdd[d] = mq[d][mhead[d]];
                mhead[d] = (mhead[d] + 1) % 32;
                msize[d]--;
            end
            if (wa) begin
                mq[d][(mhead[d] + msize[d]) % 32] = wd;
                msize[d]++;
            end
        end
    endtask

    function automatic logic [19:0] exp_vec(input int d);
        bit         rdv;
        logic [7:0] rdd;
        if (m_fwft(d)) begin
            rdv = msize[d] > 0;
            rdd = rdv ? mq[d][mhead[d]] : 8'h00;
        end else begin
            rdv = e_rdv[d];
            rdd = e_rdd[d];
        end
        return {rdv, rdd, msize[d] == m_depth(d), msize[d] == 0, msize[d] >= m_af(d),
                msize[d] <= m_ae(d), e_ovf[d], e_udf[d], 5'(msize[d])};
    endfunction

    // Drive one clock of stimulus, advance the model, settle past the edge.
    task automatic cycle(input bit we, input bit re, input logic [7:0] wd, input bit r);
        @(negedge clk);
        wr_en = we; rd_en = re; wr_data = wd; rst = r;
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_step(d, we, re, wd, r);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cycle(1'b1, 1'b1, 8'h55, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs[d] !== RST_VEC) begin
                errors++; $display("FAIL reset dut%0d: got %h want %h", d, obs[d], RST_VEC);
            end
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    errors++; $display("FAIL fill model dut%0d wr%0d: got %h want %h", d, i, obs[d], exp_vec(d));
                end
            end
            checks++;
            if (ia.almost_full !== (i >= 13)) begin
                errors++; $display("FAIL fill almost_full wr%0d: got %b want %b", i, ia.almost_full, i >= 13);
            end
            checks++;
            if (ia.overflow !== (i == 16)) begin
                errors++; $display("FAIL fill overflow wr%0d: got %b want %b", i, ia.overflow, i == 16);
            end
        end
        checks++;
        if (ia.full !== 1'b1 || ia.count !== 5'd16) begin
            errors++; $display("FAIL fill full/count: got %b/%0d want 1/16", ia.full, ia.count);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    errors++; $display("FAIL drain model dut%0d rd%0d: got %h want %h", d, i, obs[d], exp_vec(d));
                end
            end
            checks++;
            if (ia.rd_valid !== 1'b1 || ia.rd_data !== 8'(i)) begin
                errors++; $display("FAIL drain data rd%0d: got %b/%h want 1/%h", i, ia.rd_valid, ia.rd_data, 8'(i));
            end
            checks++;
            if (ia.almost_empty !== (15 - i <= 2)) begin
                errors++; $display("FAIL drain almost_empty rd%0d: got %b want %b", i, ia.almost_empty, 15 - i <= 2);
            end
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (ia.rd_valid !== 1'b0 || ia.rd_data !== 8'h0F || ia.empty !== 1'b1) begin
            errors++; $display("FAIL drain pulse: got v%b d%h e%b want v0 d0f e1", ia.rd_valid, ia.rd_data, ia.empty);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (ia.underflow !== 1'b1 || ia.rd_valid !== 1'b0) begin
            errors++; $display("FAIL underflow: got u%b v%b want u1 v0", ia.underflow, ia.rd_valid);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (ia.underflow !== 1'b0) begin
            errors++; $display("FAIL underflow pulse width: got %b want 0", ia.underflow);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] w [3];
        for (int rep = 0; rep < 4; rep++) begin
            for (int k = 0; k < 3; k++) begin
                w[k] = 8'($urandom);
                cycle(1'b1, 1'b0, w[k], 1'b0);
            end
            for (int k = 0; k < 3; k++) begin
                cycle(1'b0, 1'b1, 8'h00, 1'b0);
                checks++;
                if (ib.rd_valid !== 1'b1 || ib.rd_data !== w[k]) begin
                    errors++; $display("FAIL wrap rep%0d k%0d: got %b/%h want 1/%h", rep, k, ib.rd_valid, ib.rd_data, w[k]);
                end
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (obs[d] !== exp_vec(d)) begin
                        errors++; $display("FAIL wrap model dut%0d: got %h want %h", d, obs[d], exp_vec(d));
                    end
                end
            end
        end
        checks++;
        if (ib.count !== 3'd0 || ib.empty !== 1'b1) begin
            errors++; $display("FAIL wrap end count: got %0d/%b want 0/1", ib.count, ib.empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
            checks++;
            if (ia.count !== 5'd16 || ia.overflow !== 1'b0 || ia.rd_valid !== 1'b1) begin
                errors++; $display("FAIL full rw cnt/ovf/vld: got %0d/%b/%b want 16/0/1", ia.count, ia.overflow, ia.rd_valid);
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    errors++; $display("FAIL full rw model dut%0d: got %h want %h", d, obs[d], exp_vec(d));
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    errors++; $display("FAIL full rw drain dut%0d: got %h want %h", d, obs[d], exp_vec(d));
                end
            end
        end
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        checks++;
        if (ia.underflow !== 1'b1 || ia.count !== 5'd1 || ia.overflow !== 1'b0) begin
            errors++; $display("FAIL empty rw udf/cnt/ovf: got %b/%0d/%b want 1/1/0", ia.underflow, ia.count, ia.overflow);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (ia.rd_data !== 8'h77 || ia.rd_valid !== 1'b1) begin
            errors++; $display("FAIL empty rw data: got %b/%h want 1/77", ia.rd_valid, ia.rd_data);
        end
    endtask

    task automatic test_fwft();
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'hA5, 1'b0);
        checks++;
        if (ic.rd_valid !== 1'b1 || ic.rd_data !== 8'hA5 || ic.count !== 3'd1) begin
            errors++; $display("FAIL fwft head: got v%b d%h c%0d want v1 da5 c1", ic.rd_valid, ic.rd_data, ic.count);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (ic.rd_valid !== 1'b0 || ic.empty !== 1'b1) begin
            errors++; $display("FAIL fwft pop: got v%b e%b want v0 e1", ic.rd_valid, ic.empty);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (ic.rd_valid !== 1'b1 || ic.rd_data !== 8'h41) begin
            errors++; $display("FAIL fwft next head: got v%b d%h want v1 d41", ic.rd_valid, ic.rd_data);
        end
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs[d] !== RST_VEC) begin
                errors++; $display("FAIL midburst reset dut%0d: got %h want %h", d, obs[d], RST_VEC);
            end
        end
        cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        checks++;
        if (ic.rd_valid !== 1'b1 || ic.rd_data !== 8'h3C) begin
            errors++; $display("FAIL midburst fwft head: got v%b d%h want v1 d3c", ic.rd_valid, ic.rd_data);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (ia.rd_valid !== 1'b1 || ia.rd_data !== 8'h3C || ia.empty !== 1'b1) begin
            errors++; $display("FAIL midburst read: got v%b d%h e%b want v1 d3c e1", ia.rd_valid, ia.rd_data, ia.empty);
        end
    endtask

    task automatic test_random();
        bit we, re, r;
        for (int i = 0; i < 600; i++) begin
            we = $urandom_range(0, 99) < 55;
            re = $urandom_range(0, 99) < 50;
            r  = $urandom_range(0, 79) == 0;
            cycle(we, re, 8'($urandom), r);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    errors++; $display("FAIL random dut%0d cyc%0d: got %h want %h", d, i, obs[d], exp_vec(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_reset_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/syn_fifo_param.md
Name: syn_fifo_param

Overview:
Parametrised synchronous FIFO. It is the successor to the fixed-size syn_FIFO and keeps the same wr/rd handshake and the same full/empty/rd_valid semantics. It adds configurable width and depth (non-power-of-two allowed), programmable almost-full and almost-empty thresholds, an occupancy count, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer and drops into the existing interface/driver/monitor environment.

Parameters:
- DATA_W, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries, ≥2, any integer.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request (standard mode) / head acknowledge (FWFT mode).
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data is valid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  CNT_W  occupancy; CNT_W = $clog2(DEPTH+1).
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=1 at an edge) has priority over all requests and produces:
  - wr_ptr = 0, rd_ptr = 0, count = 0, rd_data = 0.
  - rd_valid = 0, full = 0, empty = 1, almost_full = 0, almost_empty = 1, overflow = 0, underflow = 0.
  - Memory contents are not cleared, but stale entries are never readable after reset.
  - Reset mid-burst discards all contents; the first write after reset is the first word read.
- Write acceptance: wr_accept = wr_en & (!full | rd_accept).
  - A rejected write (wr_en & !wr_accept) drops its data and pulses overflow for the next cycle.
- Read acceptance: rd_accept = rd_en & !empty.
  - A rejected read (rd_en & empty) pulses underflow for the next cycle.
  - In FWFT mode, rd_en & !rd_valid counts as a rejected read.
- Simultaneous events:
  - Full and wr_en & rd_en: both accepted, count unchanged, no overflow.
  - Empty and wr_en & rd_en: write accepted, read rejected, underflow pulses, count becomes 1.
- Pointers: each increments modulo DEPTH (DEPTH-1 wraps to 0); no power-of-two assumption.
- Count: count_next = count + wr_accept - rd_accept. All status flags are registered, derived from count_next and updated on the same edge as count.
- Standard mode (FWFT=0):
  - An accepted read at edge N drives rd_data = mem[rd_ptr] and rd_valid = 1 after edge N.
  - rd_valid is a 1-cycle pulse per accepted read; rd_data holds its value between reads.
- FWFT mode (FWFT=1):
  - rd_valid = !empty and rd_data = mem[rd_ptr] whenever rd_valid = 1.
  - A word written at edge N is visible at the head after edge N.
  - rd_en pops the head; the next word appears after the same edge.
  - rd_data is don't-care while rd_valid = 0 (the bench checks it only when rd_valid = 1).
- Read-during-write to the same address cannot occur: it only happens when the FIFO is full or empty, and those cases are covered by the rules above.
- Elaboration fails (assertion) if DEPTH < 2 or either threshold is out of range.

Decomposition:
- Package fifo_pkg holds:
  - the function cnt_width(depth) = $clog2(depth+1);
  - the mode constants FIFO_STD = 0 and FIFO_FWFT = 1;
  - a struct fifo_status_t {full, empty, almost_full, almost_empty, overflow, underflow} shared with the monitor and scoreboard.
- One sub-module, fifo_mem_dp: DATA_W x DEPTH memory with a synchronous write port and an asynchronous read port. The pointer, count and flag control plus the output register stay in syn_fifo_param.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F with FWFT=0 → full = 1 after the 16th edge; almost_full = 1 after the 14th; count = 16. A 17th write pulses overflow and is dropped.
- From full, 16 reads → rd_data = 0x00..0x0F in order, each with a 1-cycle rd_valid pulse one cycle after rd_en; empty = 1 and almost_empty = 1 when count ≤ 2. A further read pulses underflow, and rd_valid stays 0.
- DEPTH = 5: 3 writes, 3 reads, repeated 4 times → pointer wrap-around verified; data preserved in order; count returns to 0.
- Simultaneous wr_en & rd_en while full (count = 16) → count stays 16, no overflow, output order preserved. While empty → write accepted, underflow pulses, count = 1.
- FWFT = 1: write 0xA5 at edge N → rd_valid = 1 and rd_data = 0xA5 after edge N. Pulse rd_en → rd_valid = 0 and empty = 1 after the next edge.
- Assert rst after 7 writes → all outputs at reset values on the next edge. Then write 0x3C and read it → rd_data = 0x3C, with no stale data.
